// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define ITER_DIVIDER_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] Data_1_i,
    input  logic [XLEN-1:0] Data_2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] Data_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic             is_rem_q, neg_quo_q, neg_rem_q;

    logic            is_signed, sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, overflow, early_out, short_path, accept;
    logic [XLEN-1:0] short_result;
    logic [XLEN:0]   rem_sh, trial;
    logic            trial_ok;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_result;

    assign is_signed = ~op_i[0];
    assign sign1     = is_signed & Data_1_i[XLEN-1];
    assign sign2     = is_signed & Data_2_i[XLEN-1];
    assign mag1      = sign1 ? -Data_1_i : Data_1_i;
    assign mag2      = sign2 ? -Data_2_i : Data_2_i;
    assign div_zero  = (Data_2_i == '0);
    assign overflow  = is_signed && (Data_1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&Data_2_i);

`ifdef ITER_DIVIDER_EARLY_OUT_EN
    assign early_out = !div_zero && (mag1 < mag2);
`else
    assign early_out = 1'b0;
`endif

    assign short_path = div_zero | overflow | early_out;
    assign accept     = (state == S_IDLE) && start_i && !flush_i;

    // One-cycle answers: x/0 gives all ones and x, overflow gives MIN and 0,
    // early-out gives 0 and the untouched dividend.
    always_comb begin
        if (div_zero)
            short_result = op_i[1] ? Data_1_i : '1;
        else if (overflow)
            short_result = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else
            short_result = op_i[1] ? Data_1_i : '0;
    end

    // The partial remainder is always below the divisor, so its shifted form
    // fits in XLEN+1 bits and the trial sign bit is the borrow.
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign trial_ok = ~trial[XLEN];

    assign quo_fix    = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix    = neg_rem_q ? -rem_q : rem_q;
    assign fix_result = is_rem_q ? rem_fix : quo_fix;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = short_path ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)
                    state_nxt = S_IDLE;
                else if (count == '0)
                    state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = flush_i ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            Data_o    <= '0;
        end else begin
            if (accept) begin
                count     <= CNT_W'(XLEN - 1);
                rem_q     <= '0;
                quo_q     <= mag1;
                dvs_q     <= mag2;
                is_rem_q  <= op_i[1];
                neg_quo_q <= sign1 ^ sign2;
                neg_rem_q <= sign1;
                if (short_path)
                    Data_o <= short_result;
            end else if (state == S_CALC) begin
                rem_q <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], trial_ok};
                count <= count - 1'b1;
            end else if (state == S_FIX && !flush_i) begin
                Data_o <= fix_result;
            end
        end
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed RV32M cases, abort/reset scenarios,
// and randomized operations compared against an arithmetic reference model.
module tb_iter_divider;

    localparam int XLEN = 32;

    logic            clk_i    = 1'b0;
    logic            rst_i    = 1'b1;
    logic            start_i  = 1'b0;
    logic [1:0]      op_i     = 2'b00;
    logic [XLEN-1:0] Data_1_i = '0;
    logic [XLEN-1:0] Data_2_i = '0;
    logic            flush_i  = 1'b0;
    logic            busy_o, done_o;
    logic [XLEN-1:0] Data_o;

    int tests = 0;
    int fails = 0;

    iter_divider #(.XLEN(XLEN)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .Data_1_i(Data_1_i),
        .Data_2_i(Data_2_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .Data_o  (Data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural result of an RV32M divide, straight from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!op[0] && a[31]) ? -a : a;
        mb = (!op[0] && b[31]) ? -b : b;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Reference model: cycles left until (and including) the done cycle, plus the visible result.
    int          mdl_cyc  = 0;
    logic [31:0] mdl_data = '0;
    logic [31:0] mdl_pend = '0;
    bit          chk_en   = 1'b0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mdl_cyc  = 0;
            mdl_data = '0;
        end else if (mdl_cyc == 0) begin
            if (start_i && !flush_i) begin
                mdl_cyc  = ref_latency(op_i, Data_1_i, Data_2_i);
                mdl_pend = ref_result(op_i, Data_1_i, Data_2_i);
                if (mdl_cyc == 1) mdl_data = mdl_pend;
            end
        end else if (flush_i && mdl_cyc > 1) begin
            mdl_cyc = 0;
        end else begin
            mdl_cyc--;
            if (mdl_cyc == 1) mdl_data = mdl_pend;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy_o), 32'(mdl_cyc > 0));
            check("cyc_done", 32'(done_o), 32'(mdl_cyc == 1));
            check("cyc_data", Data_o, mdl_data);
        end
    end

    // Issue one operation, optionally poke start_i with other operands mid-flight.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_val, input int exp_lat,
                         input int poke_at);
        int lat, busy_n;
        bit seen;
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = op; Data_1_i = a; Data_2_i = b;
        @(posedge clk_i); #1;
        start_i = 1'b0; op_i = ~op; Data_1_i = ~a; Data_2_i = ~b;
        lat = 0; busy_n = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (busy_o) busy_n++;
            if (done_o) seen = 1'b1;
            if (lat == poke_at) begin
                start_i = 1'b1; op_i = 2'b11; Data_1_i = 32'd9; Data_2_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_busy"}, busy_n, exp_lat);
        check({name, "_val"}, Data_o, exp_val);
    endtask

    initial begin
        #1 rst_i = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_data", Data_o, 32'd0);

        // Pin the reference model against hand-computed values.
        check("mdl_div", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("mdl_rem", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("mdl_rem_negdiv", ref_result(2'b10, 32'd7, 32'hFFFF_FFFE), 32'h1);
        check("mdl_ovf", ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, -1);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, -1);
        do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, -1);
        do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, -1);
        do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h1, 34, -1);
        do_op("divu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34, -1);
        do_op("div_by0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
        do_op("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5, 1, -1);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, -1);

        // Flush during CALC: no done, Data_o keeps the previous result.
        begin
            logic [31:0] prev;
            int dones;
            prev = Data_o;
            @(posedge clk_i); #1;
            start_i = 1'b1; op_i = 2'b01; Data_1_i = 32'd1000; Data_2_i = 32'd3;
            @(posedge clk_i); #1;
            start_i = 1'b0;
            repeat (9) @(posedge clk_i);
            #1 flush_i = 1'b1;
            @(posedge clk_i); #1;
            flush_i = 1'b0;
            @(negedge clk_i);
            check("flush_busy", 32'(busy_o), 32'd0);
            check("flush_data", Data_o, prev);
            dones = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_i);
                if (done_o) dones++;
            end
            check("flush_no_done", dones, 0);
        end

        // start and flush together in IDLE: nothing starts.
        @(posedge clk_i); #1;
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; Data_1_i = 32'd50; Data_2_i = 32'd5;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_start_idle", 32'(busy_o), 32'd0);

        do_op("busy_ignore", 2'b01, 32'd100, 32'd7, 32'd14, 34, 5);
        do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, -1);

        // Asynchronous reset mid-operation.
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 2'b00; Data_1_i = 32'd12345; Data_2_i = 32'd67;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_data", Data_o, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b1;

        do_op("rem_12345_67", 2'b10, 32'd12345, 32'd67, 32'd17, 34, -1);
`ifdef ITER_DIVIDER_EARLY_OUT_EN
        do_op("remu_3_10", 2'b11, 32'd3, 32'd10, 32'd3, 1, -1);
`else
        do_op("remu_3_10", 2'b11, 32'd3, 32'd10, 32'd3, 34, -1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                3:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(0, 20));
                default: a = -32'($urandom_range(0, 1000));
            endcase
            do_op("rand", op, a, b, ref_result(op, a, b), ref_latency(op, a, b), -1);
        end

        repeat (3) @(negedge clk_i);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle integer divide/remainder unit in the EX stage, alongside the single-cycle ALU.
- Performs the inverse of the ALU MUL path: RV32M DIV, DIVU, REM and REMU.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Hazard logic stalls IF/ID/EX on busy_o and captures Data_o when done_o pulses.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i
Data_1_i  input  XLEN  dividend; sampled with start_i
Data_2_i  input  XLEN  divisor; sampled with start_i
flush_i  input  1  synchronous abort (branch flush)
busy_o  output  1  high while an operation is in progress (CALC, FIX, DONE)
done_o  output  1  one-cycle pulse; result valid
Data_o  output  XLEN  result; held until next completion

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, busy_o = 0, done_o = 0, Data_o = 0, counter = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i = 1, flush_i = 0, at edge t0:
  - latch op and operands.
  - Signed ops (DIV/REM): take magnitudes; record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Divisor == 0 -> DONE:
    - quotient = all ones; remainder = Data_1_i.
    - done_o high in cycle after t0 (latency 1).
  - Signed op with Data_1_i = 0x80000000 and Data_2_i = 0xFFFFFFFF -> DONE:
    - quotient = 0x80000000; remainder = 0.
    - latency 1.
  - Otherwise -> CALC, counter = XLEN-1.
- CALC, each edge:
  - shift {rem, quo} left by 1.
  - trial = rem - divisor (XLEN+1 bits).
  - If trial is non-negative: rem = trial, quo[0] = 1.
  - Counter decrements; at counter == 0 -> FIX.
  - Exactly XLEN iteration edges.
- FIX, one edge:
  - apply two's-complement negation to quotient/remainder per recorded signs.
  - Data_o = quotient (op 00/01) or remainder (op 10/11).
  - -> DONE.
- DONE:
  - done_o = 1 for exactly one cycle; next edge -> IDLE.
  - Normal latency: done_o high XLEN+2 cycles after t0 (34 for XLEN = 32).
- Data_o changes only on entering DONE; stable otherwise.
- Remainder takes the sign of the dividend; quotient truncates toward zero.
- start_i while busy_o = 1: ignored; no queuing.
- flush_i = 1 in CALC or FIX:
  - next state IDLE; done_o never asserted; Data_o retains old value.
- flush_i in DONE: done_o still pulses; the pipeline discards it.
- flush_i and start_i together in IDLE: flush wins; no operation starts.
- Back-to-back: start_i accepted in the first IDLE cycle after DONE.
- Reset mid-operation: immediate return to IDLE; all outputs 0.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_OUT_EN.
- Defined:
  - In IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero) -> DONE directly.
  - Result: quotient = 0, remainder = Data_1_i unchanged; latency 1.
- Undefined: such operands take the full CALC path (latency XLEN+2) with identical results.

Test Plan:
- DIVU 100/7 -> Data_o = 14, done_o exactly 34 cycles after start; REMU 100/7 -> 2; busy_o high for 34 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 0x00000001; DIV 0xFFFFFFFF/0xFFFFFFFF (DIVU) -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, each with done_o one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same -> 0, latency 1.
- Abort and stall:
  - Start DIVU 1000/3, assert flush_i at cycle 10 -> busy_o low next cycle, no done_o, Data_o unchanged.
  - Pulse start_i while busy with other operands -> ignored.
  - Then DIVU 9/3 -> 3.
- Reset and early-out:
  - Drop rst_i at cycle 20 of DIV 12345/67 -> outputs 0 immediately.
  - After release, REM 12345/67 -> 17 (latency 34).
  - With ITER_DIVIDER_EARLY_OUT_EN, REMU 3/10 -> 3 with latency 1; without it, latency 34.
